// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   In-order dual-issue scheduler sitting between the two decode lanes and
//   the execute stage. Decoded packets are buffered in a circular queue;
//   a register scoreboard tracks in-flight writes. Each cycle the two oldest
//   queued packets are offered to execute, subject to RAW/WAW hazards and the
//   pairing rules (one memory op per pair, control flow only in slot 0).
//
// Ports
//   clk, reset_n     clock (rising edge), synchronous active-low reset
//   in_valid[1:0]    decode lane mask, bit0 = older lane (2'b10 treated as 2'b00)
//   in_ctrl[1:0]     decoded packets, [0] is older
//   in_ready         at least two queue entries free (registered occupancy only)
//   flush            discard every queued packet
//   issue_valid[1:0] slot mask to execute (2'b10 never driven)
//   issue_ctrl[1:0]  queue head (slot 0) and head+1 (slot 1)
//   issue_ready      execute accepts every valid slot this cycle
//   wb_valid, wb_rd  two writeback lanes clearing scoreboard bits
//   occupancy        number of queued entries
//   perf_stall_cnt   cycles with a non-empty queue, issue_ready=1, nothing issued
//   perf_dual_cnt    cycles in which both slots fire
//
// Configuration
//   SCHED_PERF_CNT_EN  when defined, the two perf ports are saturating 32-bit
//                      counters cleared by reset only; otherwise they are tied
//                      to zero and no counter flops exist.

package sched_pkg;
  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_valid;
    logic        rs2_valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        is_jumpr;
  } control_type;
endpackage

module dual_issue_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_REGS    = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [1:0]                     in_valid,
  input  sched_pkg::control_type [1:0]   in_ctrl,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [1:0]                     issue_valid,
  output sched_pkg::control_type [1:0]   issue_ctrl,
  input  logic                           issue_ready,
  input  logic [1:0]                     wb_valid,
  input  logic [1:0][4:0]                wb_rd,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
  output logic [31:0]                    perf_stall_cnt,
  output logic [31:0]                    perf_dual_cnt
);
  import sched_pkg::*;

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  control_type          queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]     head_reg;
  logic [PTR_W-1:0]     tail_reg;
  logic [OCC_W-1:0]     occ_reg;
  logic [NUM_REGS-1:0]  busy_reg;
  logic [NUM_REGS-1:0]  busy_next;
  logic [NUM_REGS-1:0]  set_vec;
  logic [NUM_REGS-1:0]  clr_vec;

  control_type          slot0;
  control_type          slot1;
  logic                 slot0_ok;
  logic                 slot1_ok;
  logic                 s0_writes;
  logic                 pair_raw;
  logic                 pair_waw;
  logic [1:0]           fire;
  logic [1:0]           deq_cnt;
  logic [1:0]           enq_cnt;
  logic                 enq0;
  logic                 enq1;

  // x0 is hard-wired zero and therefore never waits on a producer.
  function automatic logic reg_busy(input logic [4:0] r, input logic [NUM_REGS-1:0] b);
    return (r != 5'd0) && b[r];
  endfunction

  function automatic logic sb_hazard(input control_type c, input logic [NUM_REGS-1:0] b);
    return (c.rs1_valid && reg_busy(c.rs1, b)) ||
           (c.rs2_valid && reg_busy(c.rs2, b)) ||
           (c.reg_write && reg_busy(c.rd, b));
  endfunction

  function automatic logic is_ctrl(input control_type c);
    return c.is_branch || c.is_jump || c.is_jumpr;
  endfunction

  function automatic logic is_mem(input control_type c);
    return c.mem_read || c.mem_write;
  endfunction

  // Only registered occupancy is used, so a same-cycle dequeue does not
  // open up space; this keeps in_ready off the issue_ready path.
  assign in_ready  = (occ_reg <= OCC_W'(QUEUE_DEPTH - 2));
  assign occupancy = occ_reg;

  // Lane 1 is only taken together with lane 0, which also drops 2'b10.
  assign enq0    = in_ready && in_valid[0] && !flush;
  assign enq1    = enq0 && in_valid[1];
  assign enq_cnt = {1'b0, enq0} + {1'b0, enq1};

  assign slot0 = queue_mem[head_reg];
  assign slot1 = queue_mem[head_reg + PTR_W'(1)];
  assign issue_ctrl[0] = slot0;
  assign issue_ctrl[1] = slot1;

  always_comb begin
    slot0_ok  = (occ_reg != '0) && !sb_hazard(slot0, busy_reg);
    s0_writes = slot0.reg_write && (slot0.rd != 5'd0);
    pair_raw  = s0_writes &&
                ((slot1.rs1_valid && (slot1.rs1 == slot0.rd)) ||
                 (slot1.rs2_valid && (slot1.rs2 == slot0.rd)));
    pair_waw  = s0_writes && slot1.reg_write && (slot1.rd == slot0.rd);
    slot1_ok  = slot0_ok && (occ_reg >= OCC_W'(2)) &&
                !sb_hazard(slot1, busy_reg) && !pair_raw && !pair_waw &&
                !(is_mem(slot0) && is_mem(slot1)) &&
                !is_ctrl(slot0) && !is_ctrl(slot1);
  end

  assign issue_valid = {slot1_ok, slot0_ok};
  assign fire        = issue_valid & {2{issue_ready}};
  assign deq_cnt     = {1'b0, fire[0]} + {1'b0, fire[1]};

  // Per-register set/clear; OR-ing the set last makes a same-cycle
  // set beat a clear of the same register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign set_vec[gi] = 1'b0;
      end else begin : g_xn
        assign set_vec[gi] = (fire[0] && slot0.reg_write && (slot0.rd == 5'(gi))) ||
                             (fire[1] && slot1.reg_write && (slot1.rd == 5'(gi)));
      end
      assign clr_vec[gi] = (wb_valid[0] && (wb_rd[0] == 5'(gi))) ||
                           (wb_valid[1] && (wb_rd[1] == 5'(gi)));
    end
  endgenerate

  assign busy_next = (busy_reg & ~clr_vec) | set_vec;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
      busy_reg <= '0;
    end else begin
      // Scoreboard updates even on flush: fired slots are older than it.
      busy_reg <= busy_next;
      if (flush) begin
        head_reg <= tail_reg;
        occ_reg  <= '0;
      end else begin
        head_reg <= head_reg + PTR_W'(deq_cnt);
        tail_reg <= tail_reg + PTR_W'(enq_cnt);
        occ_reg  <= occ_reg + OCC_W'(enq_cnt) - OCC_W'(deq_cnt);
      end
    end
  end

  // Queue storage needs no reset; validity is carried by occupancy.
  always_ff @(posedge clk) begin
    if (enq0) queue_mem[tail_reg] <= in_ctrl[0];
    if (enq1) queue_mem[tail_reg + PTR_W'(1)] <= in_ctrl[1];
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] dual_cnt_reg;
  logic        stall_cycle;

  assign stall_cycle = (occ_reg != '0) && issue_ready && (issue_valid == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_reg <= '0;
      dual_cnt_reg  <= '0;
    end else begin
      if (stall_cycle && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if ((fire == 2'b11) && (dual_cnt_reg != 32'hFFFF_FFFF))
        dual_cnt_reg <= dual_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_dual_cnt  = dual_cnt_reg;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_dual_cnt  = 32'd0;
`endif

endmodule
